// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory request per access,
// stalls the pipeline until the ack, and returns load data right-aligned.
module mem_stage_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] MEM_alu_out,
    input  logic [31:0]       MEM_rs2_data,
    input  logic [2:0]        MEM_funct3,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic              im_stall,
    input  logic              CSR_stall,
    input  logic              CSR_reset,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic [31:0]       MEM_data_memory,
    output logic              dm_stall,
    output logic              misalign_exc
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t            state_q;
    logic              dm_req_q;
    logic              dm_we_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [3:0]        dm_wstrb_q;
    logic [31:0]       dm_wdata_q;
    logic [31:0]       ld_data_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;

    logic              acc_s;
    logic              mis_s;
    logic              issue_s;
    logic [4:0]        shift_s;
    logic [31:0]       shifted_s;
    logic              dm_stall_s;

    function automatic logic f_misaligned(input logic [2:0] f3, input logic [1:0] off);
        f_misaligned = (((f3 == 3'd1) || (f3 == 3'd5)) && off[0]) ||
                       ((f3 == 3'd2) && (off != 2'b00));
    endfunction

    function automatic logic [3:0] f_strb(input logic we, input logic [2:0] f3, input logic [1:0] off);
        if (!we) begin
            f_strb = 4'b0000;
        end else begin
            case (f3)
                3'd0:    f_strb = 4'b0001 << off;
                3'd1:    f_strb = 4'b0011 << {off[1], 1'b0};
                3'd2:    f_strb = 4'b1111;
                default: f_strb = 4'b0000;
            endcase
        end
    endfunction

    function automatic logic [31:0] f_wdata(input logic we, input logic [2:0] f3, input logic [31:0] rs2);
        if (!we) begin
            f_wdata = 32'd0;
        end else begin
            case (f3)
                3'd0:    f_wdata = {4{rs2[7:0]}};
                3'd1:    f_wdata = {2{rs2[15:0]}};
                3'd2:    f_wdata = rs2;
                default: f_wdata = 32'd0;
            endcase
        end
    endfunction

    assign acc_s   = MEM_MemRead | MEM_MemWrite;
    assign mis_s   = f_misaligned(MEM_funct3, MEM_alu_out[1:0]);
    assign issue_s = acc_s & ~mis_s & ~CSR_reset;

    // Load alignment shift, taken from the access captured at issue time.
    always_comb begin
        shift_s = 5'd0;
        case (f3_q)
            3'd0, 3'd4: shift_s = {off_q, 3'b000};
            3'd1, 3'd5: shift_s = {off_q[1], 4'b0000};
            default:    shift_s = 5'd0;
        endcase
    end

    assign shifted_s = dm_rdata >> shift_s;

    // Pipeline hold: raised from the issue cycle until the ack has been taken.
    always_comb begin
        dm_stall_s = 1'b0;
        case (state_q)
            ST_IDLE:  dm_stall_s = acc_s & ~mis_s;
            ST_BUSY:  dm_stall_s = 1'b1;
            ST_DRAIN: dm_stall_s = 1'b1;
            ST_DONE:  dm_stall_s = 1'b0;
            default:  dm_stall_s = 1'b0;
        endcase
    end

    // Request FSM; a flush while busy still waits for the ack so the memory is never left mid-transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wstrb_q <= 4'b0000;
            dm_wdata_q <= 32'd0;
            ld_data_q  <= 32'd0;
            f3_q       <= 3'd0;
            off_q      <= 2'b00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_s) begin
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= MEM_MemWrite;
                        dm_addr_q  <= {MEM_alu_out[ADDR_W-1:2], 2'b00};
                        dm_wstrb_q <= f_strb(MEM_MemWrite, MEM_funct3, MEM_alu_out[1:0]);
                        dm_wdata_q <= f_wdata(MEM_MemWrite, MEM_funct3, MEM_rs2_data);
                        f3_q       <= MEM_funct3;
                        off_q      <= MEM_alu_out[1:0];
                        state_q    <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        dm_req_q <= 1'b0;
                        if (CSR_reset) begin
                            state_q <= ST_IDLE;
                        end else begin
                            ld_data_q <= dm_we_q ? 32'd0 : shifted_s;
                            state_q   <= ST_DONE;
                        end
                    end else if (CSR_reset) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (CSR_reset) begin
                        state_q <= ST_IDLE;
                    end else if (im_stall | CSR_stall) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (dm_ack) begin
                        dm_req_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    dm_req_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign dm_req          = dm_req_q;
    assign dm_we           = dm_we_q;
    assign dm_addr         = dm_addr_q;
    assign dm_wstrb        = dm_wstrb_q;
    assign dm_wdata        = dm_wdata_q;
    assign MEM_data_memory = ld_data_q;
    assign dm_stall        = dm_stall_s;
    assign misalign_exc    = (state_q == ST_IDLE) & acc_s & mis_s;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: a byte-level memory model predicts each
// request and load result; a monitor compares them as the DUT presents them.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MEM_alu_out, MEM_rs2_data;
    logic [2:0]  MEM_funct3;
    logic        MEM_MemRead, MEM_MemWrite, im_stall, CSR_stall, CSR_reset;
    logic        dm_req, dm_we, dm_ack, dm_stall, misalign_exc;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, MEM_data_memory;
    logic [3:0]  dm_wstrb;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] data_q[$];
    logic [7:0]  ref_bytes[int unsigned];
    logic [31:0] dev_mem[int unsigned];
    logic [31:0] last_data;
    int          ack_delay = 1;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .MEM_alu_out(MEM_alu_out), .MEM_rs2_data(MEM_rs2_data),
        .MEM_funct3(MEM_funct3), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .im_stall(im_stall), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MEM_data_memory(MEM_data_memory), .dm_stall(dm_stall), .misalign_exc(misalign_exc)
    );

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        return (wa * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        if (ref_bytes.exists(a)) return ref_bytes[a];
        w = init_word({a[31:2], 2'b00});
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] wa, input logic [31:0] w);
        dev_mem[wa] = w;
        for (int i = 0; i < 4; i++) ref_bytes[wa + i] = w[8*i +: 8];
    endtask

    // Memory device: acks after ack_delay request cycles, performs reads and strobed writes.
    initial begin
        int cnt;
        logic [31:0] w;
        cnt = 0;
        dm_ack = 1'b0;
        dm_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            dm_ack = 1'b0;
            if (reset && dm_req) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    cnt = 0;
                    dm_ack = 1'b1;
                    w = dev_mem.exists(dm_addr) ? dev_mem[dm_addr] : init_word(dm_addr);
                    if (dm_we) begin
                        for (int i = 0; i < 4; i++)
                            if (dm_wstrb[i]) w[8*i +: 8] = dm_wdata[8*i +: 8];
                        dev_mem[dm_addr] = w;
                        dm_rdata = $urandom;
                    end else begin
                        dm_rdata = w;
                    end
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: pops expectations when a request appears and when a completion lands.
    initial begin
        logic req_prev, ack_prev, cur_valid;
        req_t cur;
        logic [31:0] e;
        req_prev = 1'b0; ack_prev = 1'b0; cur_valid = 1'b0; cur = '0;
        forever begin
            @(negedge clk);
            if (ack_prev) begin
                if (data_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_data: got %h, expected no completion", MEM_data_memory);
                end else begin
                    e = data_q.pop_front();
                    check("mem_data", MEM_data_memory, e);
                end
            end
            if (dm_req) begin
                if (!req_prev) begin
                    if (req_q.size() == 0) begin
                        n_vec++; n_err++; cur_valid = 1'b0;
                        $display("FAIL unexpected_req: got addr %h, expected no request", dm_addr);
                    end else begin
                        cur = req_q.pop_front();
                        cur_valid = 1'b1;
                    end
                end
                if (cur_valid) begin
                    check("dm_addr", dm_addr, cur.addr);
                    check("dm_we", {31'd0, dm_we}, {31'd0, cur.we});
                    check("dm_wstrb", {28'd0, dm_wstrb}, {28'd0, cur.strb});
                    check("dm_wdata", dm_wdata, cur.wdata);
                end
            end
            ack_prev = reset && dm_req && dm_ack;
            req_prev = dm_req;
        end
    end

    // One access; entered and left just after a rising edge. k>0 flushes in busy cycle k, h>0 holds DONE.
    task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rs2, input int d, input int k, input int h,
                         input logic use_csr);
        logic mis;
        logic [31:0] word, exp;
        int nb, cnt;
        req_t r;
        nb  = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        mis = (a % nb) != 0;
        ack_delay = d;
        MEM_alu_out = a; MEM_rs2_data = rs2; MEM_funct3 = f3;
        MEM_MemRead = !st; MEM_MemWrite = st; CSR_reset = 1'b0;
        im_stall = (h > 0) && !use_csr; CSR_stall = (h > 0) && use_csr;
        if (mis) begin
            @(negedge clk);
            check("misalign_exc", {31'd0, misalign_exc}, 32'd1);
            check("mis_stall", {31'd0, dm_stall}, 32'd0);
            @(posedge clk); #1;
            MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; im_stall = 1'b0; CSR_stall = 1'b0;
            @(negedge clk);
            check("mis_no_req", {31'd0, dm_req}, 32'd0);
            @(posedge clk); #1;
            return;
        end
        r.addr = a & ~32'd3;
        r.we   = st;
        r.strb = st ? 4'((1 << nb) - 1) << (a % 4) : 4'd0;
        r.wdata = 32'd0;
        if (st) for (int i = 0; i < 4; i++) r.wdata[8*i +: 8] = rs2[8*(i % nb) +: 8];
        req_q.push_back(r);
        if (st) begin
            for (int i = 0; i < nb; i++) ref_bytes[a + i] = rs2[8*i +: 8];
            exp = 32'd0;
        end else begin
            for (int i = 0; i < 4; i++) word[8*i +: 8] = ref_rd(r.addr + i);
            exp = (nb == 4) ? word : word >> (8 * (a % 4));
        end
        if (k == 0) last_data = exp;
        data_q.push_back(last_data);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (c == 0) check("misalign_aligned", {31'd0, misalign_exc}, 32'd0);
            if (!dm_stall) break;
            cnt++;
            @(posedge clk); #1;
            if (k > 0 && c + 1 == k) CSR_reset = 1'b1;
            else if (k > 0 && c + 1 == k + 1) begin
                CSR_reset = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0;
            end
        end
        check("stall_cycles", cnt, d + 1);
        if (k == 0) begin
            check("done_no_req", {31'd0, dm_req}, 32'd0);
            for (int i = 1; i <= h; i++) begin
                @(posedge clk); #1;
                if (i == h) begin im_stall = 1'b0; CSR_stall = 1'b0; end
                @(negedge clk);
                check("hold_stall", {31'd0, dm_stall}, 32'd0);
                check("hold_no_req", {31'd0, dm_req}, 32'd0);
                check("hold_data", MEM_data_memory, last_data);
            end
        end
        @(posedge clk); #1;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; im_stall = 1'b0; CSR_stall = 1'b0; CSR_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] f3;
        logic st;
        int d, k, h;
        req_t r;
        reset = 1'b0; MEM_alu_out = 32'd0; MEM_rs2_data = 32'd0; MEM_funct3 = 3'd0;
        MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; im_stall = 1'b0; CSR_stall = 1'b0; CSR_reset = 1'b0;
        last_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'd0, dm_req}, 32'd0);
        check("rst_we", {31'd0, dm_we}, 32'd0);
        check("rst_addr", dm_addr, 32'd0);
        check("rst_strb", {28'd0, dm_wstrb}, 32'd0);
        check("rst_wdata", dm_wdata, 32'd0);
        check("rst_data", MEM_data_memory, 32'd0);
        check("rst_stall", {31'd0, dm_stall}, 32'd0);
        check("rst_misalign", {31'd0, misalign_exc}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        preload(32'h100, 32'hDEAD_BEEF);
        do_op(1'b0, 3'd2, 32'h100, 32'd0, 1, 0, 0, 1'b0);
        check("lw_deadbeef", MEM_data_memory, 32'hDEAD_BEEF);
        preload(32'h100, 32'h80FF_1122);
        do_op(1'b0, 3'd0, 32'h103, 32'd0, 1, 0, 0, 1'b0);
        check("lb_0x103", MEM_data_memory, 32'h0000_0080);
        do_op(1'b0, 3'd5, 32'h102, 32'd0, 2, 0, 0, 1'b0);
        check("lhu_0x102", MEM_data_memory, 32'h0000_80FF);
        do_op(1'b1, 3'd0, 32'h201, 32'h0000_00AB, 1, 0, 0, 1'b0);
        check("sb_data", MEM_data_memory, 32'd0);
        do_op(1'b1, 3'd1, 32'h202, 32'h0000_1234, 1, 0, 0, 1'b0);
        do_op(1'b0, 3'd2, 32'h101, 32'd0, 1, 0, 0, 1'b0);
        do_op(1'b0, 3'd2, 32'h200, 32'd0, 5, 0, 0, 1'b0);
        check("lw_after_stores", MEM_data_memory, 32'h1234_AB00 | (init_word(32'h200) & 32'h0000_00FF));
        do_op(1'b0, 3'd1, 32'h202, 32'd0, 1, 0, 3, 1'b0);
        do_op(1'b0, 3'd2, 32'h100, 32'd0, 4, 2, 0, 1'b0);
        check("flush_keeps_data", MEM_data_memory, 32'h0000_1234);

        // Reset while a load is outstanding.
        preload(32'h104, 32'hCAFE_F00D);
        ack_delay = 8;
        MEM_alu_out = 32'h104; MEM_funct3 = 3'd2; MEM_MemRead = 1'b1;
        r = '{addr: 32'h104, we: 1'b0, strb: 4'd0, wdata: 32'd0};
        req_q.push_back(r);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; MEM_MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_req", {31'd0, dm_req}, 32'd0);
        check("rst_busy_data", MEM_data_memory, 32'd0);
        check("rst_busy_stall", {31'd0, dm_stall}, 32'd0);
        last_data = 32'd0;
        @(posedge clk); #1;
        do_op(1'b0, 3'd2, 32'h104, 32'd0, 1, 0, 0, 1'b0);
        check("lw_after_reset", MEM_data_memory, 32'hCAFE_F00D);

        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            case ($urandom_range(0, st ? 2 : 4))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                default: f3 = 3'd5;
            endcase
            d = $urandom_range(1, 4);
            k = ($urandom_range(0, 4) == 0) ? $urandom_range(1, d) : 0;
            h = (k == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            do_op(st, f3, $urandom_range(0, 127), $urandom, d, k, h, 1'($urandom_range(0, 1)));
        end

        repeat (2) @(negedge clk);
        check("req_q_drained", req_q.size(), 32'd0);
        check("data_q_drained", data_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
